fifo_bus_tx: RTL and testbench

//  Drain side of the device FIFO. Pops words from an upstream FIFO and transmits each one onto the

---
 rtl/fifo_bus_pkg.sv | 19 +
 rtl/fifo_tx_hold.sv | 23 ++
 rtl/fifo_bus_tx.sv | 118 +++++++++++
 tb/tb_fifo_bus_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_bus_pkg.sv
// Shared types and defaults for the FIFO-to-bus transmit slice.
package fifo_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SEND    = 2'd2,
        BACKOFF = 2'd3
    } tx_state_t;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_ID_W     = 4;
    localparam int DEF_WAIT_MAX = 15;

    function automatic logic [DEF_ID_W-1:0] dest_of(input logic [DEF_WIDTH-1:0] word);
        return word[DEF_WIDTH-1 -: DEF_ID_W];
    endfunction

endpackage

// File: rtl/fifo_tx_hold.sv
// One-entry holding register for the word currently owned by the transmitter.
module fifo_tx_hold #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (load) begin
            dout <= din;
        end else if (clear) begin
            dout <= '0;
        end
    end

endmodule

// File: rtl/fifo_bus_tx.sv
// Drains an upstream fall-through FIFO onto the shared bus via req/gnt, one beat per word.
// Optional grant timeout with backoff is enabled by defining BUS_TIMEOUT_EN.
module fifo_bus_tx
    import fifo_bus_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ID_W     = DEF_ID_W,
    parameter int WAIT_MAX = DEF_WAIT_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_dato_i,
    output logic             fifo_pop_o,
    output logic             bus_req_o,
    input  logic             bus_gnt_i,
    output logic             bus_valid_o,
    output logic [WIDTH-1:0] bus_data_o,
    output logic [ID_W-1:0]  bus_dest_o,
    output logic             busy_o,
    output logic [15:0]      tx_count_o,
    output logic             err_o
);

    if (WAIT_MAX < 1 || ID_W >= WIDTH) begin : g_bad_cfg
        $error("fifo_bus_tx: WAIT_MAX must be >= 1 and ID_W < WIDTH");
    end

    tx_state_t        state;
    logic [WIDTH-1:0] hold_q;
    logic             hold_clear;

    // Pop is gated by rst_n so nothing leaves the FIFO while reset is held.
    assign fifo_pop_o = rst_n && (state == IDLE) && !fifo_empty_i;
    assign hold_clear = (state == SEND);
    assign busy_o     = (state != IDLE);
    assign bus_dest_o = bus_data_o[WIDTH-1 -: ID_W];

    fifo_tx_hold #(.WIDTH(WIDTH)) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (fifo_pop_o),
        .clear (hold_clear),
        .din   (fifo_dato_i),
        .dout  (hold_q)
    );

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bus_req_o   <= 1'b0;
            bus_valid_o <= 1'b0;
            bus_data_o  <= '0;
            tx_count_o  <= '0;
`ifdef BUS_TIMEOUT_EN
            wait_cnt    <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty_i) begin
                        state     <= REQ;
                        bus_req_o <= 1'b1;
`ifdef BUS_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end
                end
                REQ: begin
                    if (bus_gnt_i) begin
                        state       <= SEND;
                        bus_valid_o <= 1'b1;
                        bus_data_o  <= hold_q;
                    end
`ifdef BUS_TIMEOUT_EN
                    // Last ungranted cycle of the wait window: drop req for one cycle, keep the word.
                    else if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
                        state     <= BACKOFF;
                        bus_req_o <= 1'b0;
                        err_q     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                SEND: begin
                    state       <= IDLE;
                    bus_req_o   <= 1'b0;
                    bus_valid_o <= 1'b0;
                    bus_data_o  <= '0;
                    tx_count_o  <= tx_count_o + 16'd1;
                end
`ifdef BUS_TIMEOUT_EN
                BACKOFF: begin
                    state     <= REQ;
                    bus_req_o <= 1'b1;
                    wait_cnt  <= '0;
                end
`endif
                default: begin
                    state     <= IDLE;
                    bus_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_bus_tx.sv
// Directed bench for fifo_bus_tx with an upstream FIFO model and a beat scoreboard.
module tb_fifo_bus_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_empty_i;
    logic [15:0] fifo_dato_i;
    logic        fifo_pop_o;
    logic        bus_req_o;
    logic        bus_gnt_i;
    logic        bus_valid_o;
    logic [15:0] bus_data_o;
    logic [3:0]  bus_dest_o;
    logic        busy_o;
    logic [15:0] tx_count_o;
    logic        err_o;

    fifo_bus_tx #(.WIDTH(16), .ID_W(4), .WAIT_MAX(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty_i (fifo_empty_i),
        .fifo_dato_i  (fifo_dato_i),
        .fifo_pop_o   (fifo_pop_o),
        .bus_req_o    (bus_req_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_valid_o  (bus_valid_o),
        .bus_data_o   (bus_data_o),
        .bus_dest_o   (bus_dest_o),
        .busy_o       (busy_o),
        .tx_count_o   (tx_count_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    logic [15:0] fifo_q[$];
    logic [15:0] exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic        pop_prev = 1'b0;
    logic        prev_valid = 1'b0;
    int          pop_cnt = 0;
    int          beat_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd();
        fifo_empty_i = (fifo_q.size() == 0);
        fifo_dato_i  = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0000;
    endtask

    task automatic push(input logic [15:0] w);
        fifo_q.push_back(w);
        upd();
    endtask

    // One clock: sample pop mid-cycle, update FIFO model and scoreboard just after the edge.
    task automatic step();
        logic        pop_s;
        logic [15:0] w;
        @(negedge clk);
        pop_s = fifo_pop_o;
        if (fifo_empty_i) chk("pop_while_empty", pop_s, 0);
        if (pop_s) exp_q.push_back(fifo_q[0]);
        @(posedge clk);
        #1;
        if (pop_s) begin
            void'(fifo_q.pop_front());
            upd();
            pop_cnt++;
        end
        pop_prev = pop_s;
        if (bus_valid_o) begin
            beat_cnt++;
            if (exp_q.size() == 0) begin
                chk("beat_expected", bus_valid_o, 0);
            end else begin
                w = exp_q.pop_front();
                chk("beat_data", bus_data_o, w);
                chk("beat_dest", bus_dest_o, w[15:12]);
            end
            chk("valid_one_cycle", prev_valid, 0);
        end
        prev_valid = bus_valid_o;
    endtask

    initial begin
        int pop_at[$];
        logic [15:0] cnt0;

        // Test 1: reset with a word waiting, then first transfer
        rst_n = 1'b0;
        bus_gnt_i = 1'b0;
        upd();
        push(16'h6123);
        #2;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_pop", pop_prev, 0);
        end
        chk("rst_req", bus_req_o, 0);
        chk("rst_valid", bus_valid_o, 0);
        chk("rst_data", bus_data_o, 0);
        chk("rst_count", tx_count_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        rst_n = 1'b1;
        step();
        chk("t1_pop", pop_prev, 1);
        chk("t1_req", bus_req_o, 1);
        chk("t1_busy", busy_o, 1);
        chk("t1_valid_pre", bus_valid_o, 0);
        bus_gnt_i = 1'b1;
        step();
        chk("t1_valid", bus_valid_o, 1);
        chk("t1_req_in_send", bus_req_o, 1);
        bus_gnt_i = 1'b0;
        step();
        chk("t1_valid_off", bus_valid_o, 0);
        chk("t1_data_off", bus_data_o, 0);
        chk("t1_count", tx_count_o, 1);

        // Test 2: two words, grant held high
        cnt0 = tx_count_o;
        push(16'h0006);
        push(16'h000A);
        bus_gnt_i = 1'b1;
        beat_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (pop_prev) pop_at.push_back(i);
        end
        chk("t2_pops", pop_at.size(), 2);
        if (pop_at.size() == 2) chk("t2_pop_spacing", pop_at[1] - pop_at[0], 3);
        chk("t2_beats", beat_cnt, 2);
        chk("t2_count", tx_count_o, cnt0 + 16'd2);
        bus_gnt_i = 1'b0;

        // Test 3: grant withheld for 10 cycles
        pop_cnt = 0;
        beat_cnt = 0;
        push(16'h9BEE);
        step();
        chk("t3_req", bus_req_o, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_req_hold", bus_req_o, 1);
            chk("t3_no_valid", bus_valid_o, 0);
            chk("t3_err", err_o, 0);
        end
        bus_gnt_i = 1'b1;
        step();
        chk("t3_valid", bus_valid_o, 1);
        bus_gnt_i = 1'b0;
        step();
        step();
        chk("t3_pops", pop_cnt, 1);
        chk("t3_beats", beat_cnt, 1);

        // Test 4: stray grant while idle and empty
        cnt0 = tx_count_o;
        bus_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_no_valid", bus_valid_o, 0);
            chk("t4_no_pop", pop_prev, 0);
            chk("t4_no_req", bus_req_o, 0);
        end
        chk("t4_count", tx_count_o, cnt0);
        bus_gnt_i = 1'b0;

        // Test 5: reset during REQ drops the held word
        push(16'h3C55);
        push(16'h7A01);
        step();
        chk("t5_req", bus_req_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_req", bus_req_o, 0);
        chk("t5_async_busy", busy_o, 0);
        chk("t5_async_count", tx_count_o, 0);
        chk("t5_no_pop", fifo_pop_o, 0);
        exp_q.delete();
        step();
        chk("t5_rst_pop", pop_prev, 0);
        rst_n = 1'b1;
        step();
        chk("t5_pop", pop_prev, 1);
        bus_gnt_i = 1'b1;
        step();
        chk("t5_valid", bus_valid_o, 1);
        chk("t5_data", bus_data_o, 16'h7A01);
        bus_gnt_i = 1'b0;
        step();
        chk("t5_count", tx_count_o, 1);

`ifdef BUS_TIMEOUT_EN
        // Test 6: grant timeout with backoff, word retained
        push(16'h5ABC);
        step();
        for (int i = 0; i < 14; i++) begin
            step();
            chk("t6_req", bus_req_o, 1);
            chk("t6_err_pre", err_o, 0);
        end
        step();
        chk("t6_err", err_o, 1);
        chk("t6_backoff_req", bus_req_o, 0);
        chk("t6_busy", busy_o, 1);
        step();
        chk("t6_req_again", bus_req_o, 1);
        bus_gnt_i = 1'b1;
        step();
        chk("t6_valid", bus_valid_o, 1);
        chk("t6_data", bus_data_o, 16'h5ABC);
        bus_gnt_i = 1'b0;
        step();
        chk("t6_err_sticky", err_o, 1);
        chk("t6_count", tx_count_o, 2);
`else
        chk("err_tied_low", err_o, 0);
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
